// File: rtl/cpu_6502_ISA_pkg.sv
// ----------------------------------------------------------------------------
// cpu_6502_ISA_pkg
// Shared definitions for the 6502 core front end.
//   - fetch_state_t : fetch stage state encoding
//   - opcode field slices (cc = group, bbb = addressing mode)
//   - instr_length(): instruction length in bytes (1..3) from the opcode
// ----------------------------------------------------------------------------
package cpu_6502_ISA_pkg;

    // Opcode field positions: aaa bbb cc
    localparam int unsigned CC_LSB  = 0;
    localparam int unsigned CC_MSB  = 1;
    localparam int unsigned BBB_LSB = 2;
    localparam int unsigned BBB_MSB = 4;

    // Instruction groups (cc field)
    localparam logic [1:0] GRP_CTL = 2'b00;  // control / index-register group
    localparam logic [1:0] GRP_ALU = 2'b01;  // ORA/AND/EOR/ADC/STA/LDA/CMP/SBC
    localparam logic [1:0] GRP_RMW = 2'b10;  // shifts, INC/DEC, LDX/STX
    localparam logic [1:0] GRP_ILL = 2'b11;  // undocumented

    // Addressing modes (bbb field); the CTL and RMW groups reuse the same
    // codes with slightly different meanings, but the byte counts line up.
    localparam logic [2:0] MODE_IZX = 3'b000;
    localparam logic [2:0] MODE_ZP  = 3'b001;
    localparam logic [2:0] MODE_IMM = 3'b010;
    localparam logic [2:0] MODE_ABS = 3'b011;
    localparam logic [2:0] MODE_IZY = 3'b100;
    localparam logic [2:0] MODE_ZPX = 3'b101;
    localparam logic [2:0] MODE_ABY = 3'b110;
    localparam logic [2:0] MODE_ABX = 3'b111;

    localparam logic [7:0] OP_JSR    = 8'h20;
    localparam logic [7:0] OP_NOP_80 = 8'h80;

    typedef enum logic [1:0] {
        S_ISSUE   = 2'd0,
        S_CAPTURE = 2'd1,
        S_VALID   = 2'd2
    } fetch_state_t;

    function automatic logic [1:0] instr_length(input logic [7:0] opcode);
        logic [1:0] cc;
        logic [2:0] bbb;
        logic [1:0] len;
        cc  = opcode[CC_MSB:CC_LSB];
        bbb = opcode[BBB_MSB:BBB_LSB];
        len = 2'd1;
        case (cc)
            GRP_ALU: begin
                if (bbb == MODE_ABS || bbb == MODE_ABY || bbb == MODE_ABX) len = 2'd3;
                else                                                    len = 2'd2;
            end
            GRP_RMW: begin
                case (bbb)
                    MODE_IZX, MODE_ZP, MODE_ZPX: len = 2'd2;
                    MODE_ABS, MODE_ABX:          len = 2'd3;
                    default:                     len = 2'd1;
                endcase
            end
            GRP_CTL: begin
                if (opcode == OP_JSR) begin
                    len = 2'd3;
                end else begin
                    case (bbb)
                        // Immediate LDY/CPY/CPX; BRK/RTI/RTS/80 are single byte
                        MODE_IZX:                    len = (opcode[7] && opcode != OP_NOP_80)
                                                           ? 2'd2 : 2'd1;
                        MODE_ZP, MODE_IZY, MODE_ZPX: len = 2'd2;
                        MODE_ABS, MODE_ABX:          len = 2'd3;
                        default:                     len = 2'd1;
                    endcase
                end
            end
            default: len = 2'd1;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/cpu_6502_instr_length.sv
// ----------------------------------------------------------------------------
// cpu_6502_instr_length
// Combinational instruction-length decoder.
//   i_opcode : opcode byte
//   o_len    : instruction length in bytes (1, 2 or 3)
// ----------------------------------------------------------------------------
module cpu_6502_instr_length
    import cpu_6502_ISA_pkg::*;
(
    input  logic [7:0] i_opcode,
    output logic [1:0] o_len
);

    assign o_len = instr_length(i_opcode);

endmodule

// File: rtl/cpu_6502_fetch.sv
// ----------------------------------------------------------------------------
// cpu_6502_fetch
// Instruction fetch stage: reads opcode + operand bytes from the shared
// memory port and hands an assembled instruction to the decoder.
//   i_clk / i_rst              : clock, async active-high reset
//   i_mem_gnt                  : memory port granted this cycle
//   o_mem_rd_en / o_mem_addr   : read request (1-cycle latency)
//   i_mem_rdata                : read data, cycle after the request
//   i_redirect_valid/_pc       : PC change from execute (highest priority)
//   o_instr_valid/i_instr_ready: bundle handshake to the decoder
//   o_instr_opcode/op1/op2/len/pc : registered instruction bundle
// ----------------------------------------------------------------------------
module cpu_6502_fetch
    import cpu_6502_ISA_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h8000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_mem_gnt,
    output logic        o_mem_rd_en,
    output logic [15:0] o_mem_addr,
    input  logic [7:0]  i_mem_rdata,
    input  logic        i_redirect_valid,
    input  logic [15:0] i_redirect_pc,
    output logic        o_instr_valid,
    input  logic        i_instr_ready,
    output logic [7:0]  o_instr_opcode,
    output logic [7:0]  o_instr_op1,
    output logic [7:0]  o_instr_op2,
    output logic [1:0]  o_instr_len,
    output logic [15:0] o_instr_pc
);

    fetch_state_t r_state, w_state_n;
    logic [15:0]  r_pc, w_pc_n;
    logic [1:0]   r_byte_idx, w_byte_idx_n;
    logic [1:0]   r_len, w_len_n;
    logic [7:0]   r_opcode, w_opcode_n;
    logic [7:0]   r_op1, w_op1_n;
    logic [7:0]   r_op2, w_op2_n;

    // Output bundle, loaded only when entering S_VALID
    logic [7:0]   r_instr_opcode, r_instr_op1, r_instr_op2;
    logic [1:0]   r_instr_len;
    logic [15:0]  r_instr_pc;

    logic         w_load_out;
    logic         w_rd_en;
    logic [1:0]   w_len_decoded;

    cpu_6502_instr_length u_instr_length (
        .i_opcode (i_mem_rdata),
        .o_len    (w_len_decoded)
    );

    always_comb begin
        w_state_n    = r_state;
        w_pc_n       = r_pc;
        w_byte_idx_n = r_byte_idx;
        w_len_n      = r_len;
        w_opcode_n   = r_opcode;
        w_op1_n      = r_op1;
        w_op2_n      = r_op2;
        w_load_out   = 1'b0;
        w_rd_en      = 1'b0;

        if (i_redirect_valid) begin
            // Drops any partial instruction; a pending bundle counts as consumed.
            w_state_n    = S_ISSUE;
            w_pc_n       = i_redirect_pc;
            w_byte_idx_n = 2'd0;
        end else begin
            case (r_state)
                S_ISSUE: begin
                    if (i_mem_gnt) begin
                        w_rd_en   = 1'b1;
                        w_state_n = S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    case (r_byte_idx)
                        2'd0: begin
                            w_opcode_n = i_mem_rdata;
                            w_op1_n    = 8'h00;
                            w_op2_n    = 8'h00;
                            w_len_n    = w_len_decoded;
                        end
                        2'd1:    w_op1_n = i_mem_rdata;
                        default: w_op2_n = i_mem_rdata;
                    endcase
                    if (({1'b0, r_byte_idx} + 3'd1) < {1'b0, w_len_n}) begin
                        w_byte_idx_n = r_byte_idx + 2'd1;
                        w_state_n    = S_ISSUE;
                    end else begin
                        w_state_n  = S_VALID;
                        w_load_out = 1'b1;
                    end
                end
                S_VALID: begin
                    if (i_instr_ready) begin
                        w_pc_n       = r_pc + {14'd0, r_instr_len};
                        w_byte_idx_n = 2'd0;
                        w_state_n    = S_ISSUE;
                    end
                end
                default: w_state_n = S_ISSUE;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state        <= S_ISSUE;
            r_pc           <= RESET_PC;
            r_byte_idx     <= 2'd0;
            r_len          <= 2'd0;
            r_opcode       <= 8'h00;
            r_op1          <= 8'h00;
            r_op2          <= 8'h00;
            r_instr_opcode <= 8'h00;
            r_instr_op1    <= 8'h00;
            r_instr_op2    <= 8'h00;
            r_instr_len    <= 2'd0;
            r_instr_pc     <= RESET_PC;
        end else begin
            r_state    <= w_state_n;
            r_pc       <= w_pc_n;
            r_byte_idx <= w_byte_idx_n;
            r_len      <= w_len_n;
            r_opcode   <= w_opcode_n;
            r_op1      <= w_op1_n;
            r_op2      <= w_op2_n;
            if (w_load_out) begin
                r_instr_opcode <= w_opcode_n;
                r_instr_op1    <= w_op1_n;
                r_instr_op2    <= w_op2_n;
                r_instr_len    <= w_len_n;
                r_instr_pc     <= r_pc;
            end
        end
    end

    // Reset gating keeps the request low while reset is held, even with grant high.
    assign o_mem_rd_en    = w_rd_en & ~i_rst;
    assign o_mem_addr     = r_pc + {14'd0, r_byte_idx};
    assign o_instr_valid  = (r_state == S_VALID);
    assign o_instr_opcode = r_instr_opcode;
    assign o_instr_op1    = r_instr_op1;
    assign o_instr_op2    = r_instr_op2;
    assign o_instr_len    = r_instr_len;
    assign o_instr_pc     = r_instr_pc;

endmodule

// File: tb/tb_cpu_6502_fetch.sv
module tb_cpu_6502_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_gnt;
    logic        mem_rd_en;
    logic [15:0] mem_addr;
    logic [7:0]  mem_rdata = 8'h00;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [7:0]  instr_opcode, instr_op1, instr_op2;
    logic [1:0]  instr_len;
    logic [15:0] instr_pc;

    logic [7:0]  mem [0:65535];
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    // Memory model: 1-cycle read latency
    always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

    cpu_6502_fetch #(.RESET_PC(16'h8000)) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_mem_gnt        (mem_gnt),
        .o_mem_rd_en      (mem_rd_en),
        .o_mem_addr       (mem_addr),
        .i_mem_rdata      (mem_rdata),
        .i_redirect_valid (redirect_valid),
        .i_redirect_pc    (redirect_pc),
        .o_instr_valid    (instr_valid),
        .i_instr_ready    (instr_ready),
        .o_instr_opcode   (instr_opcode),
        .o_instr_op1      (instr_op1),
        .o_instr_op2      (instr_op2),
        .o_instr_len      (instr_len),
        .o_instr_pc       (instr_pc)
    );

    // Counts clock cycles until instr_valid; returns limit+1 on timeout.
    task automatic wait_valid(input int limit, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!instr_valid && cyc <= limit);
    endtask

    task automatic accept();
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; mem_gnt = 1'b1; redirect_valid = 1'b0; redirect_pc = 16'h0000;
        instr_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (instr_valid !== 1'b0) begin errors++;
            $display("FAIL reset_valid: got %0b want 0", instr_valid); end
        checks++; if (mem_rd_en !== 1'b0) begin errors++;
            $display("FAIL reset_rd_en: got %0b want 0", mem_rd_en); end
        checks++; if (mem_addr !== 16'h8000) begin errors++;
            $display("FAIL reset_addr: got %h want 8000", mem_addr); end
        checks++; if (instr_len !== 2'd0 || instr_opcode !== 8'h00) begin errors++;
            $display("FAIL reset_bundle: got len %0d op %h want 0 00", instr_len, instr_opcode); end
        rst = 1'b0;
        #1;
        checks++; if (mem_rd_en !== 1'b1 || mem_addr !== 16'h8000) begin errors++;
            $display("FAIL first_issue: got rd_en %0b addr %h want 1 8000", mem_rd_en, mem_addr); end
    endtask

    task automatic test_nop();
        int cyc;
        wait_valid(10, cyc);
        checks++; if (cyc !== 2) begin errors++;
            $display("FAIL nop_latency: got %0d want 2", cyc); end
        checks++; if (instr_opcode !== 8'hEA || instr_len !== 2'd1 || instr_pc !== 16'h8000
                      || instr_op1 !== 8'h00) begin errors++;
            $display("FAIL nop_bundle: got %h %h len %0d pc %h want EA 00 1 8000",
                     instr_opcode, instr_op1, instr_len, instr_pc); end
        accept();
        #1;
        checks++; if (mem_addr !== 16'h8001 || mem_rd_en !== 1'b1) begin errors++;
            $display("FAIL nop_next_addr: got %h want 8001", mem_addr); end
    endtask

    task automatic test_lda();
        int cyc;
        wait_valid(10, cyc);
        checks++; if (cyc !== 4) begin errors++;
            $display("FAIL imm_latency: got %0d want 4", cyc); end
        checks++; if (instr_opcode !== 8'hA9 || instr_op1 !== 8'h42 || instr_op2 !== 8'h00
                      || instr_len !== 2'd2 || instr_pc !== 16'h8001) begin errors++;
            $display("FAIL imm_bundle: got %h %h %h len %0d pc %h want A9 42 00 2 8001",
                     instr_opcode, instr_op1, instr_op2, instr_len, instr_pc); end
        accept();
        wait_valid(10, cyc);
        checks++; if (cyc !== 6) begin errors++;
            $display("FAIL abs_latency: got %0d want 6", cyc); end
        checks++; if (instr_opcode !== 8'hAD || instr_op1 !== 8'h34 || instr_op2 !== 8'h12
                      || instr_len !== 2'd3 || instr_pc !== 16'h8003) begin errors++;
            $display("FAIL abs_bundle: got %h %h %h len %0d pc %h want AD 34 12 3 8003",
                     instr_opcode, instr_op1, instr_op2, instr_len, instr_pc); end
        accept();
    endtask

    task automatic test_gnt_stall();
        int cyc;
        repeat (4) @(negedge clk);  // now at the op2 issue cycle
        for (int i = 0; i < 3; i++) begin
            mem_gnt = 1'b0;
            #1;
            checks++; if (mem_rd_en !== 1'b0 || mem_addr !== 16'h8008) begin errors++;
                $display("FAIL stall_rd_en[%0d]: got %0b addr %h want 0 8008", i, mem_rd_en,
                         mem_addr); end
            @(negedge clk);
        end
        mem_gnt = 1'b1;
        wait_valid(10, cyc);
        checks++; if (cyc + 7 !== 9) begin errors++;
            $display("FAIL stall_latency: got %0d want 9", cyc + 7); end
        checks++; if (instr_opcode !== 8'h8D || instr_op1 !== 8'h00 || instr_op2 !== 8'h02
                      || instr_len !== 2'd3 || instr_pc !== 16'h8006) begin errors++;
            $display("FAIL stall_bundle: got %h %h %h len %0d pc %h want 8D 00 02 3 8006",
                     instr_opcode, instr_op1, instr_op2, instr_len, instr_pc); end
        accept();
    endtask

    task automatic test_ready_hold();
        int cyc;
        wait_valid(10, cyc);
        checks++; if (cyc !== 4) begin errors++;
            $display("FAIL hold_latency: got %0d want 4", cyc); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (instr_valid !== 1'b1 || instr_opcode !== 8'hA5 || instr_op1 !== 8'h10
                          || instr_pc !== 16'h8009 || mem_rd_en !== 1'b0) begin errors++;
                $display("FAIL hold_stable[%0d]: got v%0b %h %h pc %h rd %0b want 1 A5 10 8009 0",
                         i, instr_valid, instr_opcode, instr_op1, instr_pc, mem_rd_en); end
        end
        accept();
        #1;
        checks++; if (mem_addr !== 16'h800B || mem_rd_en !== 1'b1) begin errors++;
            $display("FAIL hold_next_addr: got %h want 800B", mem_addr); end
    endtask

    task automatic test_redirect_capture();
        int cyc;
        repeat (3) @(negedge clk);  // operand-1 capture of JSR
        redirect_valid = 1'b1; redirect_pc = 16'hC000;
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        checks++; if (mem_addr !== 16'hC000 || mem_rd_en !== 1'b1) begin errors++;
            $display("FAIL redir_cap_addr: got %h want C000", mem_addr); end
        wait_valid(10, cyc);
        checks++; if (cyc !== 2) begin errors++;
            $display("FAIL redir_cap_latency: got %0d want 2", cyc); end
        checks++; if (instr_opcode !== 8'hE8 || instr_len !== 2'd1 || instr_pc !== 16'hC000
                      || instr_op1 !== 8'h00) begin errors++;
            $display("FAIL redir_cap_bundle: got %h %h len %0d pc %h want E8 00 1 C000",
                     instr_opcode, instr_op1, instr_len, instr_pc); end
    endtask

    task automatic test_redirect_accept();
        int cyc;
        instr_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 16'hC000;
        @(negedge clk);
        instr_ready = 1'b0; redirect_valid = 1'b0;
        #1;
        checks++; if (mem_addr !== 16'hC000) begin errors++;
            $display("FAIL redir_acc_addr: got %h want C000", mem_addr); end
        wait_valid(10, cyc);
        checks++; if (instr_opcode !== 8'hE8 || instr_pc !== 16'hC000 || cyc !== 2) begin errors++;
            $display("FAIL redir_acc_bundle: got %h pc %h cyc %0d want E8 C000 2",
                     instr_opcode, instr_pc, cyc); end
        // Redirect out of S_VALID, held into the following issue cycle
        redirect_valid = 1'b1; redirect_pc = 16'hFFFF;
        @(negedge clk);
        #1;
        checks++; if (mem_rd_en !== 1'b0) begin errors++;
            $display("FAIL redir_issue_rd_en: got %0b want 0", mem_rd_en); end
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        checks++; if (mem_addr !== 16'hFFFF || mem_rd_en !== 1'b1) begin errors++;
            $display("FAIL redir_issue_addr: got %h rd %0b want FFFF 1", mem_addr, mem_rd_en); end
    endtask

    task automatic test_wrap();
        int cyc;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (mem_addr !== 16'h0000) begin errors++;
            $display("FAIL wrap_op1_addr: got %h want 0000", mem_addr); end
        repeat (2) @(negedge clk);
        #1;
        checks++; if (mem_addr !== 16'h0001) begin errors++;
            $display("FAIL wrap_op2_addr: got %h want 0001", mem_addr); end
        wait_valid(10, cyc);
        checks++; if (instr_opcode !== 8'h4C || instr_op1 !== 8'h00 || instr_op2 !== 8'h80
                      || instr_len !== 2'd3 || instr_pc !== 16'hFFFF || cyc !== 2) begin errors++;
            $display("FAIL wrap_bundle: got %h %h %h len %0d pc %h want 4C 00 80 3 FFFF",
                     instr_opcode, instr_op1, instr_op2, instr_len, instr_pc); end
        accept();
        #1;
        checks++; if (mem_addr !== 16'h0002) begin errors++;
            $display("FAIL wrap_next_pc: got %h want 0002", mem_addr); end
    endtask

    task automatic test_length_table();
        logic [7:0] t_op  [13] = '{8'h60, 8'hA0, 8'h80, 8'h00, 8'h96, 8'hBE, 8'h03,
                                   8'h19, 8'h4A, 8'h24, 8'h14, 8'h08, 8'h2C};
        int         t_len [13] = '{1, 2, 1, 1, 2, 3, 1, 3, 1, 2, 2, 1, 3};
        logic [7:0] exp1, exp2;
        int         cyc;
        mem[16'h3001] = 8'h11;
        mem[16'h3002] = 8'h22;
        for (int i = 0; i < 13; i++) begin
            mem[16'h3000] = t_op[i];
            redirect_valid = 1'b1; redirect_pc = 16'h3000;
            @(negedge clk);
            redirect_valid = 1'b0;
            wait_valid(10, cyc);
            exp1 = (t_len[i] >= 2) ? 8'h11 : 8'h00;
            exp2 = (t_len[i] == 3) ? 8'h22 : 8'h00;
            checks++; if (int'(instr_len) !== t_len[i] || cyc !== 2 * t_len[i]
                          || instr_opcode !== t_op[i] || instr_op1 !== exp1
                          || instr_op2 !== exp2 || instr_pc !== 16'h3000) begin errors++;
                $display("FAIL len_%h: got len %0d cyc %0d %h %h %h want len %0d %h %h",
                         t_op[i], instr_len, cyc, instr_opcode, instr_op1, instr_op2,
                         t_len[i], exp1, exp2); end
            accept();
        end
    endtask

    task automatic test_reset_midfetch();
        int cyc;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if (instr_valid !== 1'b0 || mem_rd_en !== 1'b0 || mem_addr !== 16'h8000)
        begin errors++;
            $display("FAIL midrst_ctrl: got v%0b rd %0b addr %h want 0 0 8000",
                     instr_valid, mem_rd_en, mem_addr); end
        checks++; if (instr_opcode !== 8'h00 || instr_op1 !== 8'h00 || instr_op2 !== 8'h00
                      || instr_len !== 2'd0) begin errors++;
            $display("FAIL midrst_bundle: got %h %h %h len %0d want 00 00 00 0",
                     instr_opcode, instr_op1, instr_op2, instr_len); end
        @(negedge clk);
        rst = 1'b0;
        wait_valid(10, cyc);
        checks++; if (instr_opcode !== 8'hEA || instr_pc !== 16'h8000 || cyc !== 2) begin errors++;
            $display("FAIL midrst_refetch: got %h pc %h cyc %0d want EA 8000 2",
                     instr_opcode, instr_pc, cyc); end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h8000] = 8'hEA;
        mem[16'h8001] = 8'hA9; mem[16'h8002] = 8'h42;
        mem[16'h8003] = 8'hAD; mem[16'h8004] = 8'h34; mem[16'h8005] = 8'h12;
        mem[16'h8006] = 8'h8D; mem[16'h8007] = 8'h00; mem[16'h8008] = 8'h02;
        mem[16'h8009] = 8'hA5; mem[16'h800A] = 8'h10;
        mem[16'h800B] = 8'h20; mem[16'h800C] = 8'h00; mem[16'h800D] = 8'hC0;
        mem[16'hC000] = 8'hE8; mem[16'hC001] = 8'hA9;
        mem[16'hFFFF] = 8'h4C; mem[16'h0000] = 8'h00; mem[16'h0001] = 8'h80;

        test_reset();
        test_nop();
        test_lda();
        test_gnt_stall();
        test_ready_hold();
        test_redirect_capture();
        test_redirect_accept();
        test_wrap();
        test_length_table();
        test_reset_midfetch();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/cpu_6502_fetch.md
# cpu_6502_fetch

Instruction fetch stage of the 6502 core. Reads an opcode byte at the program counter, derives the instruction length (1–3 bytes) from the opcode's group/addressing-mode fields, fetches the operand bytes, and presents the assembled instruction to the decoder over a valid/ready handshake. It sits between the shared memory port, which it arbitrates for through `mem_gnt`, and the decoder. It owns the architectural PC apart from redirects issued by execute.

## Interface
- `RESET_PC`, default 16'h8000: PC loaded on reset. No reset-vector fetch.
- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `mem_gnt`  in  1  memory port granted to fetch this cycle
- `mem_rd_en`  out  1  read request; 1-cycle read latency
- `mem_addr`  out  16  read address
- `mem_rdata`  in  8  read data, valid the cycle after an accepted request
- `redirect_valid`  in  1  execute requests a PC change (jump/branch/RTS/RTI)
- `redirect_pc`  in  16  new PC
- `instr_valid`  out  1  instruction bundle valid
- `instr_ready`  in  1  decoder accepts the bundle
- `instr_opcode`  out  8  opcode byte
- `instr_op1` / `instr_op2`  out  8 each  operand low/high bytes; 0 when absent
- `instr_len`  out  2  1, 2 or 3
- `instr_pc`  out  16  address of the opcode

## Operation
- State machine `fetch_state_t`: S_ISSUE, S_CAPTURE, S_VALID. Registers: `pc`, `byte_idx` (0–2), `len`, opcode/op1/op2.
- S_ISSUE: `mem_addr = pc + byte_idx` (16-bit wrap). `mem_rd_en = mem_gnt`. If `mem_gnt` is high, go to S_CAPTURE; otherwise stay.
- S_CAPTURE: store `mem_rdata` into byte[byte_idx].
  - If `byte_idx == 0`, latch `len = instr_length(mem_rdata)` and clear op1/op2.
  - If `byte_idx + 1 < len`, increment `byte_idx` and return to S_ISSUE; otherwise go to S_VALID.
- S_VALID: `instr_valid = 1`; bundle held stable until `instr_ready`.
  - On accept: `pc <= pc + len` (mod 2^16), `byte_idx <= 0`, go to S_ISSUE.
- Length rules. Fields: cc = op[1:0], bbb = op[4:2].
  - cc=01: bbb ∈ {000,001,010,100,101} → 2; {011,110,111} → 3.
  - cc=10: bbb ∈ {000,001,101} → 2; {011,111} → 3; else → 1.
  - cc=00: 8'h20 (JSR) → 3; bbb=000 with op[7]=1 (except 8'h80) → 2; other bbb=000 (BRK, RTI, RTS, 8'h80) → 1; bbb ∈ {001,100,101} → 2; {011,111} → 3; {010,110} → 1.
  - cc=11: illegal → 1.
  - BRK is length 1; its padding byte is the decoder's concern.
- Redirect has priority in every state:
  - `pc <= redirect_pc`, `byte_idx <= 0`, next state S_ISSUE.
  - `mem_rd_en` is forced to 0 in the redirect cycle.
  - Read data returning the following cycle is ignored, because the FSM is back in S_ISSUE.
  - Redirect together with `instr_ready` in S_VALID: the handshake counts as accepted, and the redirect PC wins over `pc + len`.
- Reset values: state S_ISSUE, `pc = RESET_PC`, `instr_valid = 0`, `mem_rd_en = 0`, `mem_addr = RESET_PC`, opcode/op1/op2/len registers 0. Reset may assert in any state, including mid-fetch; it discards the partial instruction.

## Timing
- With `mem_gnt` held high, `instr_valid` rises 2·len cycles after the first S_ISSUE cycle: 2, 4 or 6 cycles.
- Each cycle of `mem_gnt` low in S_ISSUE adds one cycle. No requests are issued in S_CAPTURE or S_VALID.
- Back-to-back: `instr_ready` high in the first S_VALID cycle lets the next opcode issue on the following cycle.
- `instr_*` outputs are registered and change only on entry to S_VALID.

## Structure
- Shared items go in `cpu_6502_ISA_pkg`:
  - `fetch_state_t` enum.
  - `instr_length(logic [7:0])` function returning `logic [1:0]`.
  - Field-slice constants for cc/bbb, reusing the existing group/mode parameters.
- Sub-module `cpu_6502_instr_length`: combinational wrapper around `instr_length`, instantiated once and unit-testable alone.

## Test plan
- Reset, then memory holds 8'hEA at 8000 (NOP) → `instr_valid` 2 cycles after the first issue; opcode EA, len 1, pc 8000. Next fetch address is 8001.
- A9 42 at 8001 (LDA #$42) → len 2, op1 42, op2 00, valid after 4 cycles. Then AD 34 12 (LDA $1234) → len 3, op1 34, op2 12.
- `mem_gnt` low for 3 cycles during the op2 fetch of 8D 00 02 → `mem_rd_en` stays 0 while `mem_gnt` is low, and valid arrives 3 cycles late with correct bytes.
- Decoder holds `instr_ready` = 0 for 5 cycles → bundle stable and no memory requests issued. PC advances only on the accept cycle.
- `redirect_valid` with `redirect_pc` = C000 in S_CAPTURE of a 3-byte instruction → partial bytes dropped. Next `mem_addr` is C000; stale `mem_rdata` ignored. Same redirect coinciding with accept → next fetch is C000, not pc+len.
- PC = FFFF holding 4C 00 80 (wrap case) → operands fetched from 0000/0001, `instr_pc` FFFF, next pc 0002. Async reset mid-fetch → outputs return to reset values immediately.
